mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_if.sv | 38 +++
 rtl/mem_arb.sv | 70 +++++++
 tb/tb_mem_arb.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// mem_arb_if: I-side, D-side and shared downstream request/response signals of the memory arbiter
interface mem_arb_if;
    logic [63:0] im_req_addr;
    logic        im_req_valid;
    logic        im_req_ready;
    logic [63:0] im_resp_rdata;
    logic        im_resp_valid;
    logic [63:0] dm_req_addr;
    logic [63:0] dm_req_wdata;
    logic [7:0]  dm_req_wmask;
    logic        dm_req_wen;
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic [63:0] dm_resp_rdata;
    logic        dm_resp_valid;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_req_wen;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_resp_rdata;
    logic        mem_resp_valid;
    modport slave (
        input  im_req_addr, im_req_valid, output im_req_ready, im_resp_rdata, im_resp_valid,
        input  dm_req_addr, dm_req_wdata, dm_req_wmask, dm_req_wen, dm_req_valid,
        output dm_req_ready, dm_resp_rdata, dm_resp_valid,
        output mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen, mem_req_valid,
        input  mem_req_ready, mem_resp_rdata, mem_resp_valid
    );
    modport master (
        output im_req_addr, im_req_valid, input im_req_ready, im_resp_rdata, im_resp_valid,
        output dm_req_addr, dm_req_wdata, dm_req_wmask, dm_req_wen, dm_req_valid,
        input  dm_req_ready, dm_resp_rdata, dm_resp_valid,
        input  mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen, mem_req_valid,
        output mem_req_ready, mem_resp_rdata, mem_resp_valid
    );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: two-requester memory arbiter with D-side priority, I-side starvation guard and in-order response routing
module mem_arb #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input logic       clk,
    input logic       rst,
    mem_arb_if.slave  bus
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [MAX_OUTSTANDING-1:0] ids_q, ids_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic lock_q, lock_d, gnt_q, gnt_d;
    logic full, grant_d, push, pop, head;
    always_ff @(posedge clk) begin
        if (!rst) begin
            ids_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            lock_q   <= 1'b0;
            gnt_q    <= 1'b0;
        end else begin
            ids_q    <= ids_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            lock_q   <= lock_d;
            gnt_q    <= gnt_d;
        end
    end
    // A stalled request keeps its grant so the downstream payload cannot switch sides
    always_comb begin
        full    = cnt_q == CW'(MAX_OUTSTANDING);
        grant_d = lock_q ? gnt_q
                         : (bus.dm_req_valid && starve_q < SW'(STARVE_LIMIT)) || !bus.im_req_valid;
        bus.mem_req_valid = rst & (bus.im_req_valid | bus.dm_req_valid) & ~full;
        bus.im_req_ready  = rst & ~grant_d & bus.mem_req_ready & ~full;
        bus.dm_req_ready  = rst &  grant_d & bus.mem_req_ready & ~full;
        bus.mem_req_addr  = grant_d ? bus.dm_req_addr  : bus.im_req_addr;
        bus.mem_req_wdata = grant_d ? bus.dm_req_wdata : 64'd0;
        bus.mem_req_wmask = grant_d ? bus.dm_req_wmask : 8'd0;
        bus.mem_req_wen   = grant_d ? bus.dm_req_wen   : 1'b0;
        push = bus.mem_req_valid & bus.mem_req_ready;
        pop  = rst & bus.mem_resp_valid & (cnt_q != '0);
        head = ids_q[rd_q];
        bus.im_resp_valid = pop & ~head;
        bus.dm_resp_valid = pop & head;
        bus.im_resp_rdata = bus.mem_resp_rdata;
        bus.dm_resp_rdata = bus.mem_resp_rdata;
    end
    always_comb begin
        ids_d = ids_q;
        if (push) ids_d[wr_q] = grant_d;
        wr_d = push ? (wr_q == PW'(MAX_OUTSTANDING - 1) ? '0 : wr_q + PW'(1)) : wr_q;
        rd_d = pop  ? (rd_q == PW'(MAX_OUTSTANDING - 1) ? '0 : rd_q + PW'(1)) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        starve_d = (push && !grant_d) ? '0
                 : (push && bus.im_req_valid && starve_q != SW'(STARVE_LIMIT)) ? starve_q + SW'(1)
                 : starve_q;
        lock_d = bus.mem_req_valid & ~bus.mem_req_ready;
        gnt_d  = grant_d;
    end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed and random stimulus checked cycle by cycle against a queue-based reference model
module tb_mem_arb;
    localparam int MO = 2;
    localparam int SL = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    mem_arb_if bus();
    mem_arb #(.MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)) dut (.clk(clk), .rst(rst), .bus(bus));
    int errors = 0;
    int checks = 0;
    bit q[$];
    int starve = 0;
    bit lk = 1'b0;
    bit lkg = 1'b0;
    logic [9:0] glog;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.im_req_addr = '0; bus.im_req_valid = 0;
        bus.dm_req_addr = '0; bus.dm_req_wdata = '0; bus.dm_req_wmask = '0;
        bus.dm_req_wen = 0; bus.dm_req_valid = 0;
        bus.mem_req_ready = 0; bus.mem_resp_rdata = '0; bus.mem_resp_valid = 0;
    endtask

    // Checks one cycle mid-period, then advances the model across the rising edge
    task automatic cyc();
        bit full, mv, gd, acc, pop, hd;
        #4;
        full = q.size() == MO;
        mv   = rst && (bus.im_req_valid || bus.dm_req_valid) && !full;
        gd   = lk ? lkg : ((bus.dm_req_valid && starve < SL) || !bus.im_req_valid);
        acc  = mv && bus.mem_req_ready;
        pop  = rst && bus.mem_resp_valid && q.size() != 0;
        hd   = pop ? q[0] : 1'b0;
        chk("mem_req_valid", 64'(bus.mem_req_valid), 64'(mv));
        chk("im_req_ready", 64'(bus.im_req_ready), 64'(rst && !gd && bus.mem_req_ready && !full));
        chk("dm_req_ready", 64'(bus.dm_req_ready), 64'(rst && gd && bus.mem_req_ready && !full));
        chk("im_resp_valid", 64'(bus.im_resp_valid), 64'(pop && !hd));
        chk("dm_resp_valid", 64'(bus.dm_resp_valid), 64'(pop && hd));
        if (mv) begin
            chk("mem_req_addr", bus.mem_req_addr, gd ? bus.dm_req_addr : bus.im_req_addr);
            chk("mem_req_wdata", bus.mem_req_wdata, gd ? bus.dm_req_wdata : 64'd0);
            chk("mem_req_wmask", 64'(bus.mem_req_wmask), gd ? 64'(bus.dm_req_wmask) : 64'd0);
            chk("mem_req_wen", 64'(bus.mem_req_wen), gd ? 64'(bus.dm_req_wen) : 64'd0);
        end
        if (pop) chk(hd ? "dm_resp_rdata" : "im_resp_rdata",
                     hd ? bus.dm_resp_rdata : bus.im_resp_rdata, bus.mem_resp_rdata);
        glog = {glog[8:0], bus.dm_req_ready};
        if (!rst) begin
            q.delete(); starve = 0; lk = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(gd);
                if (!gd) starve = 0;
                else if (bus.im_req_valid && starve < SL) starve++;
            end
            lk  = mv && !bus.mem_req_ready;
            lkg = gd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic resp(logic [63:0] d);
        bus.mem_resp_valid = 1; bus.mem_resp_rdata = d;
        cyc();
        bus.mem_resp_valid = 0;
    endtask

    initial begin
        idle();
        @(posedge clk); #1;
        // reset with activity on the inputs: nothing may leak out
        bus.im_req_valid = 1; bus.dm_req_valid = 1; bus.mem_req_ready = 1; bus.mem_resp_valid = 1;
        cyc(); cyc();
        idle();
        rst = 1;
        cyc();
        // single I read
        bus.im_req_valid = 1; bus.im_req_addr = 64'h8000_0000; bus.mem_req_ready = 1;
        cyc();
        bus.im_req_valid = 0;
        cyc();
        resp(64'h1122_3344_5566_7788);
        cyc();
        // sustained contention: starvation guard lets I through every fifth grant
        bus.im_req_valid = 1; bus.dm_req_valid = 1; bus.dm_req_addr = 64'h40;
        bus.mem_resp_valid = 1; bus.mem_resp_rdata = 64'h5a5a;
        glog = '0;
        for (int i = 0; i < 10; i++) cyc();
        chk("grant_seq", 64'(glog), 64'(10'b1111011110));
        idle();
        resp(64'h77);
        // stalled D write, I arrives mid-stall
        bus.dm_req_valid = 1; bus.dm_req_wen = 1; bus.dm_req_addr = 64'h1000;
        bus.dm_req_wdata = 64'hAA; bus.dm_req_wmask = 8'h01;
        cyc();
        bus.im_req_valid = 1; bus.im_req_addr = 64'h2000;
        cyc(); cyc();
        bus.mem_req_ready = 1;
        cyc();
        bus.dm_req_valid = 0;
        cyc();
        // queue full: both requesters blocked until a response frees a slot
        bus.dm_req_valid = 1; bus.dm_req_wen = 0; bus.dm_req_addr = 64'h3000;
        cyc(); cyc();
        resp(64'h1);
        cyc();
        bus.im_req_valid = 0; bus.dm_req_valid = 0;
        // in-order routing, then a stray beat
        resp(64'hA1A1); resp(64'hB2B2); resp(64'hC3C3);
        // reset with two in flight, late responses discarded
        bus.im_req_valid = 1; cyc();
        bus.im_req_valid = 0; bus.dm_req_valid = 1; cyc();
        bus.dm_req_valid = 0; rst = 0; cyc();
        rst = 1;
        resp(64'hD1); resp(64'hD2);
        bus.im_req_valid = 1; bus.im_req_addr = 64'h8000_0040; cyc();
        bus.im_req_valid = 0;
        resp(64'hE1);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (!lk) begin
                bus.im_req_valid = 1'($urandom);
                bus.im_req_addr  = {$urandom, $urandom};
                bus.dm_req_valid = 1'($urandom);
                bus.dm_req_addr  = {$urandom, $urandom};
                bus.dm_req_wdata = {$urandom, $urandom};
                bus.dm_req_wmask = 8'($urandom);
                bus.dm_req_wen   = 1'($urandom);
            end
            bus.mem_req_ready  = 1'($urandom);
            bus.mem_resp_valid = ($urandom_range(0, 2) == 0);
            bus.mem_resp_rdata = {$urandom, $urandom};
            rst = ($urandom_range(0, 99) != 0);
            cyc();
        end
        rst = 1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
